// File: rtl/mmio_timer_if.sv
// Data-memory port bundle shared by the CPU and memory-mapped responders.
// The CPU drives the access; the responder returns same-cycle read data and a hit flag.
interface mmio_timer_if;
   logic [3:0]  READ_WRITE_EN;
   logic [31:0] ADDRESS;
   logic [31:0] WRITEDATA;
   logic [31:0] READDATA;
   logic        HIT;

   modport master (
      output READ_WRITE_EN,
      output ADDRESS,
      output WRITEDATA,
      input  READDATA,
      input  HIT
   );

   modport slave (
      input  READ_WRITE_EN,
      input  ADDRESS,
      input  WRITEDATA,
      output READDATA,
      output HIT
   );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, sticky status and interrupt.
// Four word registers in a 16-byte window: CTRL, COUNT, COMPARE, STATUS.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
   input  logic         CLK,
   input  logic         RESET,
   mmio_timer_if.slave  bus,
   output logic         IRQ
);

   logic        en_reg, en_next;
   logic        auto_reload_reg, auto_reload_next;
   logic        irq_en_reg, irq_en_next;
   logic [7:0]  prescale_reg, prescale_next;
   logic [7:0]  pcnt_reg, pcnt_next;
   logic [31:0] count_reg, count_next;
   logic [31:0] compare_reg, compare_next;
   logic        match_reg, match_next;

   logic [31:0] offset;
   logic        op_ok;
   logic        hit;
   logic        wr_en;
   logic        rd_en;
   logic [1:0]  reg_idx;
   logic [3:0]  wr_sel;
   logic [31:0] reg_view [4];
   logic        tick;
   logic        is_match;

   // Offset is taken relative to the base so the window need not be 16-byte aligned.
   assign offset  = bus.ADDRESS - BASE_ADDR;
   assign op_ok   = (bus.READ_WRITE_EN[3] ^ bus.READ_WRITE_EN[2]) &&
                    (bus.READ_WRITE_EN[1:0] == 2'b10);
   assign hit     = op_ok && (bus.ADDRESS[1:0] == 2'b00) &&
                    (bus.ADDRESS >= BASE_ADDR) && (offset <= 32'd12);
   assign wr_en   = hit && bus.READ_WRITE_EN[3];
   assign rd_en   = hit && bus.READ_WRITE_EN[2];
   assign reg_idx = offset[3:2];

   assign reg_view[0] = {16'h0000, prescale_reg, 5'b00000, irq_en_reg, auto_reload_reg, en_reg};
   assign reg_view[1] = count_reg;
   assign reg_view[2] = compare_reg;
   assign reg_view[3] = {31'd0, match_reg};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (reg_idx == 2'(gi));
      end
   endgenerate

   assign bus.HIT      = hit;
   assign bus.READDATA = rd_en ? reg_view[reg_idx] : 32'd0;
   assign IRQ          = match_reg & irq_en_reg;

   assign tick     = en_reg && (pcnt_reg == prescale_reg);
   assign is_match = (count_reg == compare_reg);

   always_comb begin
      en_next          = en_reg;
      auto_reload_next = auto_reload_reg;
      irq_en_next      = irq_en_reg;
      prescale_next    = prescale_reg;
      pcnt_next        = pcnt_reg;
      count_next       = count_reg;
      compare_next     = compare_reg;
      match_next       = match_reg;

      if (en_reg) begin
         pcnt_next = tick ? 8'd0 : pcnt_reg + 8'd1;
      end

      // A COUNT write overrides the tick entirely, including its match check.
      if (wr_sel[1]) begin
         count_next = bus.WRITEDATA;
      end else if (tick) begin
         if (is_match) begin
            count_next = auto_reload_reg ? 32'd0 : count_reg + 32'd1;
         end else begin
            count_next = count_reg + 32'd1;
         end
      end

      // Clear first so a same-edge match set takes priority.
      if (wr_sel[3] && bus.WRITEDATA[0]) begin
         match_next = 1'b0;
      end
      if (!wr_sel[1] && tick && is_match) begin
         match_next = 1'b1;
      end

      if (wr_sel[0]) begin
         en_next          = bus.WRITEDATA[0];
         auto_reload_next = bus.WRITEDATA[1];
         irq_en_next      = bus.WRITEDATA[2];
         prescale_next    = bus.WRITEDATA[15:8];
         pcnt_next        = 8'd0;
      end

      if (wr_sel[2]) begin
         compare_next = bus.WRITEDATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         en_reg          <= 1'b0;
         auto_reload_reg <= 1'b0;
         irq_en_reg      <= 1'b0;
         prescale_reg    <= 8'd0;
         pcnt_reg        <= 8'd0;
         count_reg       <= 32'd0;
         compare_reg     <= 32'd0;
         match_reg       <= 1'b0;
      end else begin
         en_reg          <= en_next;
         auto_reload_reg <= auto_reload_next;
         irq_en_reg      <= irq_en_next;
         prescale_reg    <= prescale_next;
         pcnt_reg        <= pcnt_next;
         count_reg       <= count_next;
         compare_reg     <= compare_next;
         match_reg       <= match_next;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed checking of mmio_timer against a cycle-level reference model.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [3:0]  WR   = 4'b1010;
   localparam logic [3:0]  RD   = 4'b0110;

   logic clk = 1'b0;
   logic rst;
   logic irq;

   mmio_timer_if bus_if ();

   mmio_timer #(.BASE_ADDR(BASE)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus_if),
      .IRQ   (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] last_rd;
   logic        last_hit;
   logic        last_irq;

   // Reference model state, expressed directly as the programmer-visible fields.
   bit          m_en, m_ar, m_ie, m_match;
   bit [7:0]    m_ps, m_pcnt;
   bit [31:0]   m_count, m_cmp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_valid(input logic [3:0] rwe, input logic [31:0] a);
      longint unsigned la = a;
      longint unsigned lb = BASE;
      return ((rwe == WR) || (rwe == RD)) && (a % 4 == 0) && (la >= lb) && (la <= lb + 12);
   endfunction

   function automatic bit [31:0] m_read(input int idx);
      case (idx)
         0:       return {16'd0, m_ps, 5'd0, m_ie, m_ar, m_en};
         1:       return m_count;
         2:       return m_cmp;
         default: return {31'd0, m_match};
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
      m_ps = 0; m_pcnt = 0; m_count = 0; m_cmp = 0;
   endtask

   task automatic model_step(input bit r, input logic [3:0] rwe, input logic [31:0] a,
                             input logic [31:0] wd);
      bit        v, tick, was_eq, set;
      int        idx;
      bit [31:0] c_old;
      if (r) begin
         model_reset();
         return;
      end
      v      = m_valid(rwe, a) && (rwe == WR);
      idx    = int'((a - BASE) / 4);
      tick   = m_en && (m_pcnt == m_ps);
      c_old  = m_count;
      was_eq = (c_old == m_cmp);
      set    = 0;
      if (m_en) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
      if (v && idx == 1) begin
         m_count = wd;
      end else if (tick) begin
         if (was_eq) begin
            set     = 1;
            m_count = m_ar ? 32'd0 : c_old + 1;
         end else begin
            m_count = c_old + 1;
         end
      end
      if (v && idx == 3 && wd[0]) m_match = 0;
      if (set) m_match = 1;
      if (v && idx == 0) begin
         m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2]; m_ps = wd[15:8]; m_pcnt = 0;
      end
      if (v && idx == 2) m_cmp = wd;
   endtask

   task automatic bus_cycle(input bit r, input logic [3:0] rwe, input logic [31:0] a,
                            input logic [31:0] wd);
      bit        v;
      bit [31:0] exp_rd;
      @(negedge clk);
      rst                  = r;
      bus_if.READ_WRITE_EN = rwe;
      bus_if.ADDRESS       = a;
      bus_if.WRITEDATA     = wd;
      #1;
      v      = m_valid(rwe, a);
      exp_rd = (v && rwe == RD) ? m_read(int'((a - BASE) / 4)) : 32'd0;
      check("hit", {31'd0, bus_if.HIT}, {31'd0, v});
      check("readdata", bus_if.READDATA, exp_rd);
      check("irq", {31'd0, irq}, {31'd0, m_match & m_ie});
      last_rd  = bus_if.READDATA;
      last_hit = bus_if.HIT;
      last_irq = irq;
      if (rwe != 4'd0 || r)
         $display("txn t=%0t rst=%0b rwe=%b addr=%h wdata=%h rdata=%h hit=%0b irq=%0b",
                  $time, r, rwe, a, wd, last_rd, last_hit, last_irq);
      @(posedge clk);
      model_step(r, rwe, a, wd);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      bus_cycle(0, WR, BASE + off, d);
   endtask

   task automatic rd(input logic [31:0] off);
      bus_cycle(0, RD, BASE + off, 32'd0);
   endtask

   task automatic idle();
      bus_cycle(0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      bus_cycle(1, 4'd0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] exp_seq [8];
      logic [31:0] wrap_seq [4];
      logic [31:0] d;
      logic [3:0]  rwe;
      logic [31:0] a;
      int          sel;
      bit          seen;

      rst = 1'b1;
      bus_if.READ_WRITE_EN = 4'd0;
      bus_if.ADDRESS       = 32'd0;
      bus_if.WRITEDATA     = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset after random register writes
      wr(8, $urandom);
      wr(4, $urandom);
      wr(0, 32'h0000_0007);
      wr(12, 32'd1);
      idle();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rd(i * 4);
         check("reset_reg", last_rd, 32'd0);
      end
      idle();
      check("reset_hit_idle", {31'd0, last_hit}, 32'd0);
      check("reset_irq", {31'd0, last_irq}, 32'd0);

      // Basic count with auto reload
      exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
      wr(8, 32'd5);
      wr(0, 32'h0000_0003);
      for (int i = 0; i < 8; i++) begin
         rd(4);
         check("basic_count", last_rd, exp_seq[i]);
      end
      rd(12);
      check("basic_status", last_rd, 32'd1);

      // Prescale and interrupt
      do_reset();
      wr(8, 32'd2);
      wr(0, 32'h0000_0305);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         idle();
         seen = last_irq;
      end
      check("irq_rise", {31'd0, seen}, 32'd1);
      rd(4);
      check("irq_count", last_rd, 32'd3);
      wr(12, 32'd1);
      idle();
      check("irq_fall", {31'd0, last_irq}, 32'd0);

      // Wrap through zero without reload
      do_reset();
      wrap_seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      wr(4, 32'hFFFF_FFFE);
      wr(8, 32'd0);
      wr(0, 32'h0000_0001);
      for (int i = 0; i < 4; i++) begin
         rd(4);
         check("wrap_count", last_rd, wrap_seq[i]);
      end
      rd(12);
      check("wrap_status", last_rd, 32'd1);

      // Decode rejects
      bus_cycle(0, 4'b1000, BASE, 32'h0000_00FF);
      check("dec_byte_hit", {31'd0, last_hit}, 32'd0);
      bus_cycle(0, WR, BASE + 2, 32'd0);
      check("dec_misalign_hit", {31'd0, last_hit}, 32'd0);
      bus_cycle(0, RD, BASE + 16, 32'd0);
      check("dec_above_hit", {31'd0, last_hit}, 32'd0);
      check("dec_above_rd", last_rd, 32'd0);
      bus_cycle(0, RD, BASE - 4, 32'd0);
      check("dec_below_hit", {31'd0, last_hit}, 32'd0);
      check("dec_below_rd", last_rd, 32'd0);
      rd(0);
      check("dec_ctrl_kept", last_rd, 32'h0000_0001);

      // Collisions: count write on a tick, status clear against a new match
      do_reset();
      wr(8, 32'h0000_0102);
      wr(0, 32'h0000_0001);
      wr(4, 32'h0000_0100);
      rd(4);
      check("coll_count", last_rd, 32'h0000_0100);
      idle();
      wr(12, 32'd1);
      rd(12);
      check("coll_status", last_rd, 32'd1);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 30) begin
            idle();
         end else if (sel < 55) begin
            rd($urandom_range(0, 3) * 4);
         end else if (sel < 63) begin
            d = $urandom;
            d[15:10] = 6'd0;
            wr(0, d);
         end else if (sel < 70) begin
            wr(4, m_cmp - $urandom_range(0, 6));
         end else if (sel < 76) begin
            wr(8, $urandom_range(0, 40));
         end else if (sel < 82) begin
            wr(12, $urandom);
         end else if (sel < 99) begin
            rwe = 4'($urandom_range(0, 15));
            a   = BASE - 4 + $urandom_range(0, 24);
            bus_cycle(0, rwe, a, $urandom);
         end else begin
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer/compare peripheral that sits on the CPU data-memory port as a responder, alongside `data_memory`. It decodes the pipeline's `READ_WRITE_EN`/`DATA_MEM_ADDRESS`/`DATA_MEM_WRITEDATA` accesses that fall in its 16-byte window, returns read data in the same cycle, and commits writes on the clock edge. It runs a prescaled 32-bit up-counter with compare match, sticky status flag and interrupt output. A top-level mux selects its `READDATA` over `data_memory`'s when `HIT` is high.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: word-aligned base of the 16-byte register window.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `READ_WRITE_EN`  in  4  access control: [3]=write, [2]=read, [1:0]=size (00 byte, 01 half, 10 word, 11 reserved); 4'b0000 = idle.
- `ADDRESS`  in  32  byte address from CPU.
- `WRITEDATA`  in  32  write data from CPU.
- `READDATA`  out  32  read data, combinational.
- `HIT`  out  1  access targets this block (top-level read mux select).
- `IRQ`  out  1  interrupt request, registered-state derived.

## Operation
- Valid access: exactly one of [3]/[2] set, size = 10 (word), `ADDRESS[1:0]`=00, `BASE_ADDR <= ADDRESS <= BASE_ADDR+12`. Anything else is ignored: no state change, `HIT`=0, `READDATA`=0.
- Registers (offset = `ADDRESS[3:2]`):
  - 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESCALE; other bits read 0, writes ignored.
  - 0x4 COUNT: current count; write loads value.
  - 0x8 COMPARE: match value.
  - 0xC STATUS: [0] MATCH (sticky); write with bit0=1 clears, bit0=0 no effect; other bits read 0.
- Prescaler: internal 8-bit `pcnt`. While EN=1: if `pcnt == PRESCALE`, assert internal `tick` and `pcnt <= 0`; else `pcnt <= pcnt+1`. While EN=0, `pcnt` holds and no tick.
- On `tick`: if COUNT == COMPARE, set MATCH and COUNT <= AUTO_RELOAD ? 0 : COUNT+1; else COUNT <= COUNT+1. COUNT wraps mod 2^32 (FFFF_FFFF -> 0) with no flag.
- `IRQ = MATCH & IRQ_EN`.

## Timing
- Reset (RESET high at a rising edge): CTRL, COUNT, COMPARE, STATUS, `pcnt` all 0; `IRQ`=0. `READDATA`/`HIT` purely follow the inputs (0 when idle). Reset mid-count discards all state; reset beats any same-cycle write.
- Reads: zero-latency combinational; return register value before the current edge's update.
- Writes: take effect at the rising edge where the access is presented; visible on reads the next cycle.
- Count rate: with PRESCALE=P and EN=1, COUNT increments once every P+1 cycles; first tick occurs P+1 edges after EN is written 1 (with `pcnt`=0).
- Simultaneous events:
  - Write to COUNT and tick in the same cycle: write wins, no increment, no match evaluation that cycle.
  - Write to CTRL: also clears `pcnt` to 0 that edge; the tick at that edge (if any) is still applied using old CTRL.
  - Write to COMPARE and tick: match uses old COMPARE.
  - STATUS clear and new match in the same cycle: set wins, MATCH stays 1.
- `IRQ` changes the cycle after MATCH or IRQ_EN changes (both are registered).

## Test plan
- Reset: drive RESET 1 for one edge after random writes -> all four registers read 0, `IRQ`=0, `HIT`=0 when idle.
- Basic count: write COMPARE=5, CTRL=0x0000_0003 (EN, AUTO_RELOAD, PRESCALE=0) -> COUNT increments every cycle, reads 0..5, then 0; STATUS reads 1 from cycle after COUNT==5 tick.
- Prescale + IRQ: CTRL=0x0000_0305 (PRESCALE=3, EN, IRQ_EN), COMPARE=2 -> COUNT steps every 4 cycles; `IRQ` rises after COUNT==2 tick (COUNT then 3); write STATUS=1 -> `IRQ` falls next cycle.
- Wrap: COUNT=FFFF_FFFE, COMPARE=0, EN, PRESCALE=0, no reload -> reads FFFF_FFFF, 0, 1; MATCH sets on the tick where COUNT==0.
- Collisions: write COUNT=0x100 on a tick cycle -> next read 0x100; STATUS clear coincident with match -> STATUS stays 1.
- Decode: byte write (size 00) to BASE, misaligned BASE+2, word read at BASE+16 and BASE-4 -> `HIT`=0, `READDATA`=0, no register change.
